// File: rtl/hyper_fifo_pkg.sv
// Shared helpers for the HyperBus data FIFO: pointer wrap rule for arbitrary depths.
package hyper_fifo_pkg;

  // Advance a pointer, wrapping to zero after the last entry (depth need not be 2^n).
  function automatic int unsigned ptr_incr(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/hyper_fifo_ctrl.sv
// Pointer, occupancy and flag control for hyper_sync_data_fifo.
// HYPER_FIFO_FALLTHROUGH_EN enables the empty-FIFO bypass decision.
module hyper_fifo_ctrl
  import hyper_fifo_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = 6,
  parameter int PTR_W        = $clog2(DEPTH),
  parameter int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic             out_ready_i,
  output logic             wr_en_o,
  output logic             bypass_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [CNT_W-1:0] count_o,
  output logic             almost_full_o,
  output logic             overflow_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             in_ready, stored_valid, bypass, push, pop;

  assign in_ready     = (count_q != CNT_W'(DEPTH));
  assign stored_valid = (count_q != '0);

`ifdef HYPER_FIFO_FALLTHROUGH_EN
  // A word offered to an empty FIFO is visible at once; it skips storage only if consumed now.
  assign bypass      = ~stored_valid & in_valid_i & out_ready_i & ~flush_i;
  assign out_valid_o = stored_valid | (in_valid_i & ~flush_i);
`else
  assign bypass      = 1'b0;
  assign out_valid_o = stored_valid;
`endif

  assign push = in_valid_i & in_ready & ~bypass;
  assign pop  = stored_valid & out_ready_i;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = PTR_W'(ptr_incr(32'(wr_ptr_q), DEPTH));
      if (pop)  rd_ptr_d = PTR_W'(ptr_incr(32'(rd_ptr_q), DEPTH));
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
      if (in_valid_i && !in_ready) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_en_o       = push & ~flush_i;
  assign bypass_o      = bypass;
  assign wr_ptr_o      = wr_ptr_q;
  assign rd_ptr_o      = rd_ptr_q;
  assign in_ready_o    = in_ready;
  assign count_o       = count_q;
  assign almost_full_o = (count_q >= CNT_W'(AFULL_THRESH));
  assign overflow_o    = overflow_q;

endmodule

// File: rtl/hyper_sync_data_fifo.sv
// Single-clock data FIFO for the HyperBus uDMA datapath; storage and read mux live here.
// HYPER_FIFO_FALLTHROUGH_EN adds a combinational empty-FIFO bypass.
module hyper_sync_data_fifo
  import hyper_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  wr_en, bypass;

  hyper_fifo_ctrl #(
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFULL_THRESH),
    .PTR_W        (PTR_W),
    .CNT_W        (CNT_W)
  ) u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush),
    .in_valid_i    (in_valid),
    .out_ready_i   (out_ready),
    .wr_en_o       (wr_en),
    .bypass_o      (bypass),
    .wr_ptr_o      (wr_ptr),
    .rd_ptr_o      (rd_ptr),
    .in_ready_o    (in_ready),
    .out_valid_o   (out_valid),
    .count_o       (count),
    .almost_full_o (almost_full),
    .overflow_o    (overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr] <= in_data;
    end
  end

`ifdef HYPER_FIFO_FALLTHROUGH_EN
  // While empty, the head is whatever is being offered on the input.
  assign out_data = (count == '0 && in_valid && !flush) ? in_data : mem_q[rd_ptr];
`else
  assign out_data = bypass ? in_data : mem_q[rd_ptr];
`endif

endmodule
